// File: rtl/source_sample_scheduler.sv
// -----------------------------------------------------------------------------
// source_sample_scheduler
//
// Shares one ADC sampling path between up to four energy sources (solar, wind,
// battery, bus). Each channel owns a programmable sample-period timer; expired
// channels become pending and are served round-robin through a start/done
// handshake with the ADC. Each result leaves as a tagged sample carrying
// over-voltage and timeout flags.
//
// Ports:
//   clk, rst              system clock, synchronous active-high reset
//   cfg_we/addr/period    period register write (period 0 disables a channel)
//   adc_sel, adc_start    channel routed to the ADC, one-cycle conversion request
//   adc_done, adc_data    conversion complete strobe with its result
//   out_valid/ready       downstream sample handshake
//   out_ch/data/ov/err    sample tag, value, over-voltage flag, timeout flag
//   overrun               sticky per-channel "expired while still pending"
//   dbg_state             current scheduler state (IDLE=0, START=1, WAIT=2, EMIT=3)
//
// Downstream handshake: out_valid rises only in EMIT and then stays high, with
// out_ch/out_data/out_ov/out_err stable, until the cycle in which out_valid and
// out_ready are both high; that cycle transfers the sample and the next cycle
// is IDLE. Reset is the only other way out of EMIT (the sample is dropped).
// -----------------------------------------------------------------------------
module source_sample_scheduler #(
    parameter int           NCH      = 4,
    parameter int           W        = 8,
    parameter logic [W-1:0] OV_LIMIT = 8'd200,
    parameter int           TIMEOUT  = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cfg_we,
    input  logic [1:0]     cfg_addr,
    input  logic [7:0]     cfg_period,
    output logic [1:0]     adc_sel,
    output logic           adc_start,
    input  logic           adc_done,
    input  logic [W-1:0]   adc_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [1:0]     out_ch,
    output logic [W-1:0]   out_data,
    output logic           out_ov,
    output logic           out_err,
    output logic [NCH-1:0] overrun,
    output logic [1:0]     dbg_state
);

    localparam int WCW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_EMIT  = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Per-channel timers
    logic [7:0]     period_q [NCH];
    logic [7:0]     period_d [NCH];
    logic [7:0]     cnt_q    [NCH];
    logic [7:0]     cnt_d    [NCH];
    logic [NCH-1:0] expire;
    logic [NCH-1:0] cfg_hit;

    logic [NCH-1:0] pending_q, pending_d;
    logic [NCH-1:0] overrun_q, overrun_d;

    // Arbitration
    logic [1:0]     last_q, last_d;
    logic           grant_valid;
    logic [1:0]     grant_ch;
    logic [1:0]     rr_idx;
    logic           take_grant;

    // Conversion and output datapath
    logic [1:0]     sel_q, sel_d;
    logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
    logic           wait_expired;
    logic [1:0]     och_q, och_d;
    logic [W-1:0]   odata_q, odata_d;
    logic           oov_q, oov_d;
    logic           oerr_q, oerr_d;

    // -------------------------------------------------------------------------
    // Configuration decode; indices at or above NCH match no channel.
    // -------------------------------------------------------------------------
    always_comb begin
        cfg_hit = '0;
        for (int i = 0; i < NCH; i++) begin
            cfg_hit[i] = cfg_we && (int'(cfg_addr) == i);
        end
    end

    // -------------------------------------------------------------------------
    // Timers: count 0..P-1 and flag expiry on the P-1 cycle. A write restarts
    // the count from zero with the new period.
    // -------------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            period_d[i] = period_q[i];
            cnt_d[i]    = cnt_q[i];
            expire[i]   = 1'b0;
            if (period_q[i] != 8'd0) begin
                if (cnt_q[i] == period_q[i] - 8'd1) begin
                    cnt_d[i]  = 8'd0;
                    expire[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + 8'd1;
                end
            end
            if (cfg_hit[i]) begin
                period_d[i] = cfg_period;
                cnt_d[i]    = 8'd0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Round-robin pick: first pending channel after the last one served.
    // -------------------------------------------------------------------------
    always_comb begin
        grant_valid = 1'b0;
        grant_ch    = '0;
        rr_idx      = '0;
        for (int k = 1; k <= NCH; k++) begin
            rr_idx = 2'((int'(last_q) + k) % NCH);
            if (!grant_valid && pending_q[rr_idx]) begin
                grant_valid = 1'b1;
                grant_ch    = rr_idx;
            end
        end
    end

    assign take_grant   = (state_q == ST_IDLE) && grant_valid;
    assign wait_expired = (wait_cnt_q == WCW'(TIMEOUT - 1));

    // -------------------------------------------------------------------------
    // Pending / overrun. A new expiry outranks the clear from a same-cycle
    // grant, so the channel is re-queued without being counted as an overrun.
    // A period write clears both bits regardless.
    // -------------------------------------------------------------------------
    always_comb begin
        pending_d = pending_q;
        overrun_d = overrun_q;
        for (int i = 0; i < NCH; i++) begin
            if (take_grant && (int'(grant_ch) == i)) begin
                pending_d[i] = 1'b0;
            end
            if (expire[i]) begin
                if (pending_q[i] && !(take_grant && (int'(grant_ch) == i))) begin
                    overrun_d[i] = 1'b1;
                end
                pending_d[i] = 1'b1;
            end
            if (cfg_hit[i]) begin
                pending_d[i] = 1'b0;
                overrun_d[i] = 1'b0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (grant_valid) state_d = ST_START;
            ST_START: state_d = ST_WAIT;
            ST_WAIT:  if (adc_done || wait_expired) state_d = ST_EMIT;
            ST_EMIT:  if (out_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs. Gated by rst so neither strobe shows during a reset cycle.
    // -------------------------------------------------------------------------
    always_comb begin
        adc_start = (state_q == ST_START) && !rst;
        out_valid = (state_q == ST_EMIT) && !rst;
        dbg_state = state_q;
    end

    // -------------------------------------------------------------------------
    // Datapath: channel select, wait counter and the captured sample.
    // adc_done wins over the timeout in the final WAIT cycle.
    // -------------------------------------------------------------------------
    always_comb begin
        sel_d      = sel_q;
        last_d     = last_q;
        wait_cnt_d = wait_cnt_q;
        och_d      = och_q;
        odata_d    = odata_q;
        oov_d      = oov_q;
        oerr_d     = oerr_q;
        if (take_grant) begin
            sel_d  = grant_ch;
            last_d = grant_ch;
        end
        if (state_q == ST_START) begin
            wait_cnt_d = '0;
        end
        if (state_q == ST_WAIT) begin
            if (adc_done) begin
                och_d   = sel_q;
                odata_d = adc_data;
                oov_d   = (adc_data >= OV_LIMIT);
                oerr_d  = 1'b0;
            end else if (wait_expired) begin
                och_d   = sel_q;
                odata_d = '0;
                oov_d   = 1'b0;
                oerr_d  = 1'b1;
            end else begin
                wait_cnt_d = wait_cnt_q + WCW'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pending_q  <= '0;
            overrun_q  <= '0;
            last_q     <= 2'(NCH - 1);
            sel_q      <= '0;
            wait_cnt_q <= '0;
            och_q      <= '0;
            odata_q    <= '0;
            oov_q      <= 1'b0;
            oerr_q     <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                period_q[i] <= 8'd0;
                cnt_q[i]    <= 8'd0;
            end
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            overrun_q  <= overrun_d;
            last_q     <= last_d;
            sel_q      <= sel_d;
            wait_cnt_q <= wait_cnt_d;
            och_q      <= och_d;
            odata_q    <= odata_d;
            oov_q      <= oov_d;
            oerr_q     <= oerr_d;
            for (int i = 0; i < NCH; i++) begin
                period_q[i] <= period_d[i];
                cnt_q[i]    <= cnt_d[i];
            end
        end
    end

    assign adc_sel  = sel_q;
    assign out_ch   = och_q;
    assign out_data = odata_q;
    assign out_ov   = oov_q;
    assign out_err  = oerr_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_source_sample_scheduler.sv
// -----------------------------------------------------------------------------
// Bench for source_sample_scheduler. Directed scenarios followed by randomized
// segments; every cycle the DUT outputs are compared with a timestamp-based
// reference model of the scheduling rules.
// -----------------------------------------------------------------------------
module tb_source_sample_scheduler;

    localparam int           NCH      = 4;
    localparam int           W        = 8;
    localparam logic [W-1:0] OV_LIMIT = 8'd200;
    localparam int           TIMEOUT  = 16;

    logic           clk;
    logic           rst;
    logic           cfg_we;
    logic [1:0]     cfg_addr;
    logic [7:0]     cfg_period;
    logic [1:0]     adc_sel;
    logic           adc_start;
    logic           adc_done;
    logic [W-1:0]   adc_data;
    logic           out_valid;
    logic           out_ready;
    logic [1:0]     out_ch;
    logic [W-1:0]   out_data;
    logic           out_ov;
    logic           out_err;
    logic [NCH-1:0] overrun;
    logic [1:0]     dbg_state;

    source_sample_scheduler #(
        .NCH(NCH), .W(W), .OV_LIMIT(OV_LIMIT), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_period(cfg_period),
        .adc_sel(adc_sel), .adc_start(adc_start),
        .adc_done(adc_done), .adc_data(adc_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ch(out_ch), .out_data(out_data), .out_ov(out_ov), .out_err(out_err),
        .overrun(overrun), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- counters ----------------
    int n_cmp;
    int n_fail;
    int cyc;

    // ---------------- environment knobs ----------------
    int           lat_lo, lat_hi;
    bit           adc_dead;
    int           ready_pct;
    bit           data_fixed;
    logic [W-1:0] fixed_val;
    int           done_at;

    // ---------------- observation ----------------
    int n_hs, n_start, n_start3, n_valid;
    int start_cyc, last_lat;
    bit prev_valid;
    int hs_ch_q[$];

    // ---------------- reference model ----------------
    int           m_per  [NCH];
    int           m_base [NCH];
    bit           m_pend [NCH];
    bit           m_ovr  [NCH];
    int           m_last;
    bit           m_busy;
    int           m_start;
    int           m_emit;
    int           m_sel, m_ch;
    logic [W-1:0] m_data;
    bit           m_ov, m_err;
    logic [W-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, expv, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_per[i] = 0; m_base[i] = 0; m_pend[i] = 0; m_ovr[i] = 0;
        end
        m_last = NCH - 1;
        m_busy = 0; m_start = -1; m_emit = -1;
        m_sel = 0; m_ch = 0; m_data = '0; m_ov = 0; m_err = 0;
        exp_q.delete();
        done_at = -1;
    endtask

    function automatic logic [W-1:0] pick_data();
        logic [W-1:0] v;
        if (data_fixed) return fixed_val;
        case ($urandom_range(5))
            0:       v = '0;
            1:       v = OV_LIMIT - 8'd1;
            2:       v = OV_LIMIT;
            3:       v = '1;
            default: v = W'($urandom);
        endcase
        return v;
    endfunction

    function automatic logic [7:0] pick_period();
        case ($urandom_range(4))
            0:       return 8'd0;
            1:       return 8'd1;
            2:       return 8'd2;
            default: return 8'($urandom_range(30, 3));
        endcase
    endfunction

    // One clock cycle: drive inputs, compare outputs, advance the model.
    task automatic step(input bit r, input bit we, input logic [1:0] a, input logic [7:0] per);
        bit           exp_start, exp_valid;
        bit           ex    [NCH];
        bit           old_p [NCH];
        int           g, ch;
        logic [NCH-1:0] mo_v;
        @(negedge clk);
        rst        = r;
        cfg_we     = we;
        cfg_addr   = a;
        cfg_period = per;
        out_ready  = (ready_pct >= 100) ? 1'b1 : (int'($urandom_range(99)) < ready_pct);
        if (cyc == done_at) begin
            adc_done = 1'b1;
            adc_data = pick_data();
        end else begin
            adc_done = 1'b0;
            adc_data = W'($urandom);
        end
        #1;
        exp_start = !r && m_busy && (cyc == m_start);
        exp_valid = !r && m_busy && (m_emit >= 0) && (cyc >= m_emit);
        for (int i = 0; i < NCH; i++) mo_v[i] = m_ovr[i];
        chk("adc_start", 32'(adc_start), 32'(exp_start));
        chk("out_valid", 32'(out_valid), 32'(exp_valid));
        if (!r) begin
            chk("adc_sel", 32'(adc_sel), m_sel);
            chk("overrun", 32'(overrun), 32'(mo_v));
        end
        if (exp_valid) begin
            chk("out_ch", 32'(out_ch), m_ch);
            chk("out_data", 32'(out_data), 32'(m_data));
            chk("out_ov", 32'(out_ov), 32'(m_ov));
            chk("out_err", 32'(out_err), 32'(m_err));
        end

        // observations feeding the ADC responder and directed checks
        if (adc_start === 1'b1) begin
            n_start++;
            start_cyc = cyc;
            if (adc_sel === 2'd3) n_start3++;
            if (!adc_dead) done_at = cyc + int'($urandom_range(lat_hi, lat_lo));
        end
        if (out_valid === 1'b1) begin
            n_valid++;
            if (!prev_valid) last_lat = cyc - start_cyc;
            if (out_ready) begin
                n_hs++;
                hs_ch_q.push_back(int'(out_ch));
            end
        end
        prev_valid = (out_valid === 1'b1);

        // model advance to the next cycle
        if (r) begin
            model_reset();
        end else begin
            g = -1;
            for (int i = 0; i < NCH; i++) begin
                old_p[i] = m_pend[i];
                ex[i] = (m_per[i] != 0) && (cyc >= m_base[i]) &&
                        (((cyc - m_base[i]) % m_per[i]) == m_per[i] - 1);
            end
            if (!m_busy) begin
                for (int k = 1; k <= NCH; k++) begin
                    ch = (m_last + k) % NCH;
                    if (g < 0 && m_pend[ch]) g = ch;
                end
                if (g >= 0) begin
                    m_busy = 1; m_start = cyc + 1; m_emit = -1;
                    m_sel = g; m_last = g;
                end
            end else if (m_emit < 0) begin
                if (cyc > m_start) begin
                    if (adc_done) begin
                        m_emit = cyc + 1; m_ch = m_sel; m_data = adc_data;
                        m_ov = (adc_data >= OV_LIMIT); m_err = 0;
                        exp_q.push_back(adc_data);
                    end else if (cyc == m_start + TIMEOUT) begin
                        m_emit = cyc + 1; m_ch = m_sel; m_data = '0;
                        m_ov = 0; m_err = 1;
                        exp_q.push_back('0);
                    end
                end
            end else if (cyc >= m_emit && out_ready) begin
                m_busy = 0;
                chk("sb_queue_nonempty", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) chk("sb_data", 32'(out_data), 32'(exp_q.pop_front()));
            end
            for (int i = 0; i < NCH; i++) begin
                if (ex[i]) begin
                    if (old_p[i] && i != g) m_ovr[i] = 1;
                    m_pend[i] = 1;
                end else if (i == g) begin
                    m_pend[i] = 0;
                end
            end
            if (we && int'(a) < NCH) begin
                m_per[a] = int'(per); m_base[a] = cyc + 1;
                m_pend[a] = 0; m_ovr[a] = 0;
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 2'd0, 8'd0);
    endtask

    // ---------------- directed then randomized sequence ----------------
    initial begin
        int hs0, nv0, ns30;
        bit seen;
        n_cmp = 0; n_fail = 0; cyc = 0;
        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_period = '0;
        adc_done = 1'b0; adc_data = '0; out_ready = 1'b1;
        lat_lo = 1; lat_hi = 1; adc_dead = 0; ready_pct = 100;
        data_fixed = 1; fixed_val = 8'd120;
        n_hs = 0; n_start = 0; n_start3 = 0; n_valid = 0;
        start_cyc = 0; last_lat = 0; prev_valid = 0;
        model_reset();

        // Reset and idle
        step(1'b1, 1'b0, 2'd0, 8'd0);
        step(1'b1, 1'b0, 2'd0, 8'd0);
        @(posedge clk); #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_adc_start", 32'(adc_start), 0);
        chk("rst_adc_sel", 32'(adc_sel), 0);
        chk("rst_out_ch", 32'(out_ch), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_out_ov", 32'(out_ov), 0);
        chk("rst_out_err", 32'(out_err), 0);
        chk("rst_overrun", 32'(overrun), 0);
        idle(100);
        chk("idle_no_start", n_start, 0);

        // Single channel, period 10, ADC answers 120 one cycle after start
        hs0 = n_hs;
        step(1'b0, 1'b1, 2'd0, 8'd10);
        idle(70);
        chk("single_count", n_hs - hs0, 6);
        chk("single_latency", last_lat, 2);

        // Round-robin, all periods 1
        step(1'b1, 1'b0, 2'd0, 8'd0);
        hs_ch_q.delete();
        for (int i = 0; i < NCH; i++) step(1'b0, 1'b1, 2'(i), 8'd1);
        idle(60);
        chk("rr_enough", 32'(hs_ch_q.size() >= 8), 1);
        for (int k = 0; k < 8 && k < hs_ch_q.size(); k++) chk("rr_order", hs_ch_q[k], k % NCH);
        chk("rr_overrun", 32'(overrun), 32'hf);

        // Backpressure on channel 1 with an over-voltage sample
        step(1'b1, 1'b0, 2'd0, 8'd0);
        fixed_val = 8'd210; ready_pct = 0;
        step(1'b0, 1'b1, 2'd1, 8'd5);
        idle(20);
        chk("bp_overrun1", 32'(overrun[1]), 1);
        chk("bp_held_valid", 32'(out_valid), 1);
        chk("bp_held_data", 32'(out_data), 210);
        chk("bp_held_ov", 32'(out_ov), 1);
        hs0 = n_hs;
        ready_pct = 100; idle(1);
        ready_pct = 0;   idle(5);
        chk("bp_one_transfer", n_hs - hs0, 1);
        ready_pct = 100; idle(30);

        // ADC timeout on channel 2
        step(1'b1, 1'b0, 2'd0, 8'd0);
        adc_dead = 1;
        last_lat = 0;
        step(1'b0, 1'b1, 2'd2, 8'd40);
        idle(80);
        chk("timeout_latency", last_lat, TIMEOUT + 1);

        // Reset during WAIT, then disable channel 3
        step(1'b1, 1'b0, 2'd0, 8'd0);
        step(1'b0, 1'b1, 2'd3, 8'd3);
        seen = 0;
        hs0 = n_start;
        for (int k = 0; k < 30; k++) begin
            step(1'b0, 1'b0, 2'd0, 8'd0);
            if (n_start != hs0) begin
                seen = 1;
                break;
            end
        end
        chk("reach_wait", 32'(seen), 1);
        step(1'b0, 1'b0, 2'd0, 8'd0);
        nv0 = n_valid; ns30 = n_start3;
        step(1'b1, 1'b0, 2'd0, 8'd0);
        step(1'b0, 1'b1, 2'd3, 8'd0);
        idle(60);
        chk("rst_no_valid", n_valid - nv0, 0);
        chk("ch3_never", n_start3 - ns30, 0);

        // Randomized segments
        data_fixed = 0;
        for (int s = 0; s < 6; s++) begin
            step(1'b1, 1'b0, 2'd0, 8'd0);
            adc_dead  = ($urandom_range(5) == 0);
            if ($urandom_range(2) == 0) begin
                lat_lo = TIMEOUT - 2; lat_hi = TIMEOUT + 2;
            end else begin
                lat_lo = 1; lat_hi = 4;
            end
            ready_pct = int'($urandom_range(100, 30));
            for (int i = 0; i < NCH; i++) step(1'b0, 1'b1, 2'(i), pick_period());
            for (int k = 0; k < 250; k++) begin
                if ($urandom_range(99) < 4)
                    step(1'b0, 1'b1, 2'($urandom_range(3)), pick_period());
                else
                    step(1'b0, 1'b0, 2'd0, 8'd0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
